// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all sysclk-domain resets, then releases them one by one in index order.
// Optional build macro RST_SEQ_EVT_CNT_EN adds the evt_cnt output (ASSERT entries caused by events).
module rst_seq_ctrl #(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned NUM_DOM  = 3,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               sysclk,
  input  logic               sys_rstn,
  input  logic               ATPG_TM,
  input  logic               ATPG_RSTN,
  input  logic [NUM_SRC-1:0] evt_req,
  input  logic [NUM_SRC-1:0] evt_mask,
  input  logic               cause_clr,
  output logic [NUM_DOM-1:0] dom_rstn_o,
  output logic               seq_busy,
  output logic               seq_done,
  output logic [NUM_SRC-1:0] rst_cause
`ifdef RST_SEQ_EVT_CNT_EN
  ,
  output logic [7:0]         evt_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NUM_SRC-1:0] cause_q;

  // Scan mode hides every event source from the sequencer.
  logic [NUM_SRC-1:0] evt_hit;
  logic               evt_vld;

  assign evt_hit = evt_req & ~evt_mask & {NUM_SRC{~ATPG_TM}};
  assign evt_vld = |evt_hit;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (ATPG_TM) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '1;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (evt_vld) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            busy_d  = 1'b1;
          end
        end

        ST_ASSERT: begin
          if (evt_vld) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
            state_d  = ST_RELEASE;
            cnt_d    = '0;
            idx_d    = '0;
            dom_d[0] = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (evt_vld) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            busy_d  = 1'b1;
          end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
            cnt_d = '0;
            if (idx_q < IDX_W'(NUM_DOM - 1)) begin
              idx_d        = idx_q + IDX_W'(1);
              dom_d[idx_d] = 1'b1;
            end else begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          if (evt_vld) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Reset puts the sequencer at the start of a hold, so power-on runs a full release.
  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cause_q <= (cause_clr ? '0 : cause_q) | evt_hit;
    end
  end

  // Scan owns the domain resets directly; status is quiet while in test mode.
  assign dom_rstn_o = ATPG_TM ? {NUM_DOM{ATPG_RSTN}} : dom_q;
  assign seq_busy   = busy_q & ~ATPG_TM;
  assign seq_done   = done_q & ~ATPG_TM;
  assign rst_cause  = cause_q;

`ifdef RST_SEQ_EVT_CNT_EN
  // Counts fresh ASSERT entries only; hold extensions and power-on are excluded.
  logic       evt_entry;
  logic [7:0] evt_cnt_base;

  assign evt_entry    = evt_vld && (state_q != ST_ASSERT);
  assign evt_cnt_base = cause_clr ? 8'd0 : evt_cnt;

  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      evt_cnt <= 8'd0;
    end else if (evt_entry && (evt_cnt_base != 8'hFF)) begin
      evt_cnt <= evt_cnt_base + 8'd1;
    end else begin
      evt_cnt <= evt_cnt_base;
    end
  end
`endif

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencer for the sysclk domain. It accepts already-synchronized reset-event requests from several sources and holds all downstream domain resets asserted for a minimum time. It then releases the domains one at a time, in index order, with a fixed gap between releases, and records which sources caused the sequence. It sits between the per-source async-event synchronizers and the domain reset trees. It has an ATPG bypass so scan controls every domain reset directly.

Parameters:
NUM_SRC, 4, number of reset-event sources
NUM_DOM, 3, number of sequenced reset domains (>=1)
HOLD_CYC, 16, cycles all domains stay in reset (>=2)
GAP_CYC, 4, cycles between consecutive domain releases (>=1)
CNT_W, 8, counter width; must hold max(HOLD_CYC,GAP_CYC)-1

Ports:
sysclk  input  1  system clock, all logic posedge
sys_rstn  input  1  asynchronous active-low reset
ATPG_TM  input  1  scan test mode; 1 = bypass
ATPG_RSTN  input  1  scan-controlled reset, drives all domains when ATPG_TM=1
evt_req  input  NUM_SRC  synchronous event requests, level or pulse, sampled each posedge
evt_mask  input  NUM_SRC  1 = ignore that source
cause_clr  input  1  one-cycle pulse clears rst_cause
dom_rstn_o  output  NUM_DOM  active-low domain resets
seq_busy  output  1  high while in ASSERT or RELEASE
seq_done  output  1  one-cycle pulse when the last domain's gap completes
rst_cause  output  NUM_SRC  sticky record of the unmasked sources that triggered a sequence

Behaviour:
- Valid event: evt_vld = |(evt_req & ~evt_mask).
- FSM states: IDLE, ASSERT, RELEASE, DONE. Counters: cnt (CNT_W bits) and dom_idx.
- sys_rstn low (async) sets:
  - state=ASSERT, cnt=0, dom_idx=0.
  - dom_rstn_o=all 0, seq_busy=1, seq_done=0, rst_cause=0.
  - After reset deassertion, the sequencer runs a full release sequence with no event.
- IDLE:
  - evt_vld at edge k → at edge k+1: state=ASSERT, all dom_rstn_o=0, cnt=0, seq_busy=1.
- ASSERT:
  - cnt increments each cycle.
  - When cnt==HOLD_CYC-1 and !evt_vld → RELEASE: dom_rstn_o[0]=1, cnt=0, dom_idx=0.
  - Domains are therefore held low for exactly HOLD_CYC cycles.
- RELEASE:
  - cnt increments each cycle.
  - When cnt==GAP_CYC-1:
    - dom_idx<NUM_DOM-1: dom_idx++, dom_rstn_o[dom_idx+1]=1, cnt=0.
    - otherwise → DONE.
  - Already-released domains stay high.
- DONE: seq_done=1 and seq_busy=0 for exactly one cycle, then IDLE.
- rst_cause update: every cycle, rst_cause <= (cause_clr ? 0 : rst_cause) | (evt_req & ~evt_mask).
  - A simultaneous set and clear leaves the new bit set.
- evt_vld in ASSERT: cnt restarts at 0, so the hold is extended.
- evt_vld in RELEASE or DONE: → ASSERT with cnt=0; all dom_rstn_o return to 0 at the next edge.
- A continuously held evt_req keeps the block in ASSERT indefinitely.
- evt_mask changes take effect on the next sample. Masking a source never clears rst_cause.
- ATPG_TM=1:
  - dom_rstn_o = {NUM_DOM{ATPG_RSTN}}, combinational mux after the flops.
  - The FSM is forced to IDLE and evt_req is ignored.
  - seq_busy=0, seq_done=0.
- ATPG_TM 1→0: FSM leaves IDLE only on a new evt_vld. Outputs revert to the registered values, which are all 1 in IDLE.
- sys_rstn assertion mid-sequence: immediate async return to the reset values above.

Optional Feature:
RST_SEQ_EVT_CNT_EN
- Defined:
  - Adds output evt_cnt [7:0]: count of ASSERT entries caused by evt_vld, including re-entries from RELEASE/DONE.
  - Extensions inside ASSERT are not counted. The power-on sequence is not counted.
  - Saturates at 255. Reset value 0. Cleared by cause_clr.
- Not defined: port and logic absent. All other behaviour is identical.

Test Plan:
1. Release sequence after sys_rstn, default params, no events → edge numbers counted from the first posedge after sys_rstn deasserts (edge 1 = cnt 0):
   - dom_rstn_o=000 through edge 15.
   - Bit 0 rises at edge 16, bit 1 at edge 20, bit 2 at edge 24.
   - seq_done pulse at edge 28.
   - rst_cause=0.
2. evt_req=4'b0010 for 1 cycle sampled at edge 0 in IDLE → at edge 1: dom_rstn_o=000, seq_busy=1, rst_cause=0010. Releases at edges 17/21/25; seq_done at edge 29.
3. Second evt_req[0] pulse while in RELEASE after dom0 released → next edge dom_rstn_o=000. Hold restarts at 16 cycles. rst_cause=0011.
4. evt_mask=4'b0100 with evt_req=4'b0100 → no state change, rst_cause unchanged. Same cycle with evt_req=4'b0101 → sequence starts, rst_cause bit0 only.
5. cause_clr and evt_req[3] at the same edge with rst_cause=0011 → rst_cause=1000.
6. ATPG_TM=1 mid-sequence, ATPG_RSTN toggled 1/0 → dom_rstn_o follows as 111/000 combinationally, seq_busy=0. ATPG_TM=0 → dom_rstn_o=111, IDLE.
